// File: rtl/lfsr_checker.sv
// lfsr_checker: self-synchronising 32-bit/cycle PRBS receive checker with lock, error pulse and BER counters
module lfsr_checker #(
    parameter int P_LOCK_CNT   = 4,
    parameter int P_UNLOCK_CNT = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_rx_data,
    input  logic        i_rx_valid,
    input  logic        i_clr_cnt,
    output logic        o_lock,
    output logic        o_err_word,
    output logic [31:0] o_err_cnt,
    output logic [31:0] o_word_cnt
);
    typedef enum logic {SEARCH, LOCKED} state_t;

    state_t      state, state_nxt;
    logic [15:0] prev_rx, prev_nxt, lfsr, lfsr_nxt;
    logic [31:0] match_cnt, match_nxt, miss_cnt, miss_nxt;
    logic [31:0] pred_search, pred_lock, diff;
    logic [31:0] s1_xor;
    logic        s1_vld;
    logic [5:0]  err_bits;
    logic [32:0] err_sum;

    // The next LFSR state is the low half of the predicted word.
    function automatic logic [31:0] prbs(input logic [15:0] s);
        logic [47:0] x;
        x = {s, 32'b0};
        for (int i = 0; i < 32; i++)
            x[31-i] = x[47-i] ^ x[46-i] ^ x[45-i] ^ x[32-i];
        return x[31:0];
    endfunction

    assign pred_search = prbs(prev_rx);
    assign pred_lock   = prbs(lfsr);
    assign diff        = i_rx_data ^ pred_lock;
    assign o_lock      = state == LOCKED;

    always_comb begin
        state_nxt = state;
        prev_nxt  = prev_rx;
        lfsr_nxt  = lfsr;
        match_nxt = match_cnt;
        miss_nxt  = miss_cnt;
        if (i_rx_valid && state == SEARCH) begin
            prev_nxt  = i_rx_data[15:0];
            match_nxt = (i_rx_data == pred_search && |prev_rx) ? match_cnt + 32'd1 : 32'd0;
            if (match_nxt == 32'(P_LOCK_CNT)) begin
                state_nxt = LOCKED;
                lfsr_nxt  = i_rx_data[15:0];
                miss_nxt  = 32'd0;
            end
        end else if (i_rx_valid) begin
            lfsr_nxt = pred_lock[15:0];
            miss_nxt = |diff ? miss_cnt + 32'd1 : 32'd0;
            if (miss_nxt == 32'(P_UNLOCK_CNT)) begin
                state_nxt = SEARCH;
                match_nxt = 32'd0;
                prev_nxt  = i_rx_data[15:0];
            end
        end
    end

    always_comb begin
        err_bits = 6'd0;
        for (int i = 0; i < 32; i++)
            err_bits = err_bits + 6'(s1_xor[i]);
        err_sum = {1'b0, o_err_cnt} + 33'(err_bits);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= SEARCH;
            prev_rx    <= 16'h0000;
            lfsr       <= 16'h0000;
            match_cnt  <= 32'd0;
            miss_cnt   <= 32'd0;
            s1_xor     <= 32'd0;
            s1_vld     <= 1'b0;
            o_err_word <= 1'b0;
            o_err_cnt  <= 32'd0;
            o_word_cnt <= 32'd0;
        end else begin
            state      <= state_nxt;
            prev_rx    <= prev_nxt;
            lfsr       <= lfsr_nxt;
            match_cnt  <= match_nxt;
            miss_cnt   <= miss_nxt;
            s1_vld     <= i_rx_valid && state == LOCKED;
            s1_xor     <= i_rx_valid ? diff : s1_xor;
            o_err_word <= s1_vld && |s1_xor;
            if (i_clr_cnt) begin
                o_err_cnt  <= 32'd0;
                o_word_cnt <= 32'd0;
            end else if (s1_vld) begin
                o_err_cnt  <= err_sum[32] ? 32'hFFFF_FFFF : err_sum[31:0];
                o_word_cnt <= &o_word_cnt ? o_word_cnt : o_word_cnt + 32'd1;
            end
        end
    end
endmodule
